usi_slave_csr: RTL
==================

# usi_slave_csr

Bus-slave endpoint for the processor's USI command bus, directly downstream of the micro-controller bus master. It decodes the master's combined command/address word, and services writes and reads to a small control/status register file. It returns read data and an access-ready flag that the master consumes as one bit of its read-data/valid inputs. It also drives control, one-shot pulse and interrupt outputs into the peripheral block it fronts.

## Interface
- pBusAdrs, 8'h00, bus address of this slave; compared against command bits [23:16].
- pPulseW, 8, width of the write-one pulse register and the event/IRQ flag register (1..16).

Ports:
- iSysClk  in  1  system clock, all logic on rising edge.
- iSysRst  in  1  asynchronous, active-low reset.
- iSUsiWd  in  32  write data (master oMUsiWd).
- iSUsiAdrs  in  32  [31:30] cmd: 0 none, 1 write, 2 read, 3 reserved; [23:16] bus adrs; [15:0] CSR adrs.
- iSUsiWCke  in  1  command strobe, one cycle per command.
- oSUsiRd  out  32  read data; zero whenever not holding a response, so slaves can be OR-combined.
- oSUsiVd  out  1  slave ready; the master may issue only while high.
- iEvent  in  pPulseW  per-bit event inputs; sets sticky flags.
- iStatus  in  16  peripheral status, sampled on STATUS read.
- oCtrl  out  32  CTRL register.
- oPulse  out  pPulseW  one-cycle pulses from SET writes.
- oIrq  out  1  registered interrupt request.

## Operation
- **Accept.** A command is accepted when all of the following hold in the same cycle:
  - iSUsiWCke=1;
  - state IDLE;
  - [23:16]==pBusAdrs;
  - cmd is 1 or 2.
- **Ignored commands.** Cmd 0/3, a foreign address, or any strobe while not IDLE is ignored: no state change, no counter change.
- **Clearing read data.** Any iSUsiWCke=1 cycle, regardless of address, clears oSUsiRd to 0 on the next edge. Acceptance of a read overrides this via the later load.
- **FSM.**
  - IDLE: write accepted goes to WACK; read accepted goes to RFETCH.
  - WACK goes to IDLE.
  - RFETCH goes to RRESP.
  - RRESP goes to IDLE.
  - oSUsiVd=1 only in IDLE.
- **CSR map (adrs[15:0]).**
  - 0x0000 CTRL: RW, reset 0, drives oCtrl.
  - 0x0004 SCRATCH: RW, reset 0.
  - 0x0008 SET: write-only. A write pulses oPulse = Wd[pPulseW-1:0] for one cycle. Reads return 0.
  - 0x000C STATUS: RO, {iStatus, wr_cnt[7:0], rd_cnt[7:0]}.
  - 0x0010 FLAG: RW1C sticky flags. iEvent bit high sets the flag. Writing 1 clears it; if set and clear occur in the same cycle, set wins.
  - Other addresses: writes are dropped; reads return 0. Both still count as accepted.
- **Counters.** wr_cnt and rd_cnt are 8-bit. Each increments on acceptance of its command type and wraps 255 to 0.
- **Interrupt.** oIrq is registered: |(FLAG & CTRL[pPulseW+7:8]), i.e. CTRL bits [15:8] are the IRQ mask for the default width.
- **Reset mid-operation.** Asserting reset forces IDLE immediately and clears all registers, counters and outputs; any in-flight command is lost.

## Timing
- **Reset values:**
  - oSUsiRd=0, oSUsiVd=1;
  - oCtrl=0, oPulse=0, oIrq=0;
  - FLAG=0, SCRATCH=0, counters=0.
- **Write (T0 = accept cycle):**
  - T1: register updated, oPulse high (SET only), oSUsiVd=0.
  - T2: oSUsiVd=1, oPulse=0.
- **Read:**
  - T1: RFETCH, register mux sampled (STATUS rd_cnt already includes this read), oSUsiVd=0.
  - T2: RRESP, oSUsiRd valid, oSUsiVd=0.
  - T3: oSUsiVd=1; oSUsiRd is held until the next iSUsiWCke cycle.
  - Master samples data on the cycle oSUsiVd returns to 1 (T3).
- **Throughput:** one write per 2 cycles, one read per 3 cycles.
- **Flag and interrupt latency:**
  - iEvent to FLAG: 1 cycle.
  - FLAG/CTRL change to oIrq: 1 further cycle.
- **Back-to-back:** a strobe at T1 or T2 is ignored, not queued.

## Test plan
- Reset released, no traffic -> oSUsiVd=1, oSUsiRd=0, oCtrl=0, oIrq=0.
- Write CTRL adrs 0x0000 data 32'h0000_A5C3 then read -> oCtrl=32'h0000_A5C3 at T1; read returns 32'h0000_A5C3 at T2; oSUsiVd low T1–T2, high T3.
- Write SET 8'h81 -> oPulse=8'h81 for exactly one cycle; subsequent SET read returns 0.
- Pulse iEvent[2]; CTRL[10]=1 -> FLAG=0x04 and oIrq=1 two cycles after event. Write FLAG 0x04 in the same cycle iEvent[2] is high -> flag stays set. Next write without event -> oIrq=0.
- Issue 256 writes to SCRATCH, 1 read of STATUS with iStatus=16'h1234 -> 32'h1234_0001 (wr_cnt wrapped to 0, rd_cnt=1).
- Cmd to pBusAdrs+1, cmd 3, and a strobe during RFETCH -> all ignored, counters unchanged. Assert reset in WACK -> oSUsiVd=1 and all registers 0 immediately.

Source files
------------

// File: rtl/usi_slave_csr.sv
// USI command-bus slave endpoint with a small control/status register file.
// Decodes the master's command/address word, performs CSR writes on the accept
// edge, and returns read data two cycles after a read is accepted. Read data
// is zero whenever no response is held, so several slaves can be OR-combined.
module usi_slave_csr #(
    parameter logic [7:0] pBusAdrs = 8'h00,
    parameter int         pPulseW  = 8
) (
    input  logic               iSysClk,
    input  logic               iSysRst,
    input  logic [31:0]        iSUsiWd,
    input  logic [31:0]        iSUsiAdrs,
    input  logic               iSUsiWCke,
    output logic [31:0]        oSUsiRd,
    output logic               oSUsiVd,
    input  logic [pPulseW-1:0] iEvent,
    input  logic [15:0]        iStatus,
    output logic [31:0]        oCtrl,
    output logic [pPulseW-1:0] oPulse,
    output logic               oIrq
);

    localparam logic [15:0] ADR_CTRL    = 16'h0000;
    localparam logic [15:0] ADR_SCRATCH = 16'h0004;
    localparam logic [15:0] ADR_SET     = 16'h0008;
    localparam logic [15:0] ADR_STATUS  = 16'h000C;
    localparam logic [15:0] ADR_FLAG    = 16'h0010;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WACK   = 2'd1,
        ST_RFETCH = 2'd2,
        ST_RRESP  = 2'd3
    } state_t;

    state_t              state_q;
    logic                vd_q;
    logic [15:0]         adrs_q;
    logic [31:0]         ctrl_q,    ctrl_d;
    logic [31:0]         scratch_q, scratch_d;
    logic [pPulseW-1:0]  flag_q,    flag_d;
    logic [pPulseW-1:0]  flag_clr;
    logic [pPulseW-1:0]  pulse_q,   pulse_d;
    logic [7:0]          wr_cnt_q,  wr_cnt_d;
    logic [7:0]          rd_cnt_q,  rd_cnt_d;
    logic                irq_q,     irq_d;
    logic [31:0]         rd_q,      rd_d;
    logic [31:0]         rd_mux;

    logic [1:0]  cmd;
    logic [15:0] csr_adrs;
    logic        hit;
    logic        acc_wr;
    logic        acc_rd;
    logic        unused_adrs_bits;

    assign cmd      = iSUsiAdrs[31:30];
    assign csr_adrs = iSUsiAdrs[15:0];
    assign hit      = iSUsiWCke && (state_q == ST_IDLE) && (iSUsiAdrs[23:16] == pBusAdrs);
    assign acc_wr   = hit && (cmd == 2'd1);
    assign acc_rd   = hit && (cmd == 2'd2);

    // Bits [29:24] of the command word carry no meaning for this slave.
    assign unused_adrs_bits = ^iSUsiAdrs[29:24];

    // Bus handshake FSM; ready is registered alongside the state it reflects.
    always_ff @(posedge iSysClk or negedge iSysRst) begin
        if (!iSysRst) begin
            state_q <= ST_IDLE;
            vd_q    <= 1'b1;
            adrs_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (acc_wr) begin
                        state_q <= ST_WACK;
                        vd_q    <= 1'b0;
                    end else if (acc_rd) begin
                        state_q <= ST_RFETCH;
                        vd_q    <= 1'b0;
                        adrs_q  <= csr_adrs;
                    end
                end
                ST_WACK: begin
                    state_q <= ST_IDLE;
                    vd_q    <= 1'b1;
                end
                ST_RFETCH: begin
                    state_q <= ST_RRESP;
                    vd_q    <= 1'b0;
                end
                ST_RRESP: begin
                    state_q <= ST_IDLE;
                    vd_q    <= 1'b1;
                end
                default: begin
                    state_q <= ST_IDLE;
                    vd_q    <= 1'b1;
                end
            endcase
        end
    end

    // Write decode: register updates, pulse generation and flag clearing on accept.
    always_comb begin
        ctrl_d    = ctrl_q;
        scratch_d = scratch_q;
        pulse_d   = '0;
        flag_clr  = '0;
        if (acc_wr) begin
            case (csr_adrs)
                ADR_CTRL:    ctrl_d    = iSUsiWd;
                ADR_SCRATCH: scratch_d = iSUsiWd;
                ADR_SET:     pulse_d   = iSUsiWd[pPulseW-1:0];
                ADR_FLAG:    flag_clr  = iSUsiWd[pPulseW-1:0];
                default:     ;
            endcase
        end
        // A new event beats a simultaneous write-one-to-clear.
        flag_d   = (flag_q & ~flag_clr) | iEvent;
        wr_cnt_d = acc_wr ? wr_cnt_q + 8'd1 : wr_cnt_q;
        rd_cnt_d = acc_rd ? rd_cnt_q + 8'd1 : rd_cnt_q;
        irq_d    = |(flag_q & ctrl_q[pPulseW+7:8]);
    end

    // Read mux, evaluated during RFETCH using the address latched at accept.
    always_comb begin
        rd_mux = '0;
        case (adrs_q)
            ADR_CTRL:    rd_mux = ctrl_q;
            ADR_SCRATCH: rd_mux = scratch_q;
            ADR_STATUS:  rd_mux = {iStatus, wr_cnt_q, rd_cnt_q};
            ADR_FLAG:    rd_mux[pPulseW-1:0] = flag_q;
            default:     rd_mux = '0;
        endcase
    end

    // Response register: loads in RFETCH, otherwise any strobe wipes it.
    always_comb begin
        rd_d = rd_q;
        if (state_q == ST_RFETCH) begin
            rd_d = rd_mux;
        end else if (iSUsiWCke) begin
            rd_d = '0;
        end
    end

    // CSR state, counters and registered outputs.
    always_ff @(posedge iSysClk or negedge iSysRst) begin
        if (!iSysRst) begin
            ctrl_q    <= '0;
            scratch_q <= '0;
            flag_q    <= '0;
            pulse_q   <= '0;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            irq_q     <= 1'b0;
            rd_q      <= '0;
        end else begin
            ctrl_q    <= ctrl_d;
            scratch_q <= scratch_d;
            flag_q    <= flag_d;
            pulse_q   <= pulse_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            irq_q     <= irq_d;
            rd_q      <= rd_d;
        end
    end

    assign oSUsiRd = rd_q;
    assign oSUsiVd = vd_q;
    assign oCtrl   = ctrl_q;
    assign oPulse  = pulse_q;
    assign oIrq    = irq_q;

endmodule
